// File: rtl/pea_cfg_ctrl_if.sv
// Configuration word stream into the PEA controller: valid/ready handshake,
// one header word followed by one control word per PE, last on the final word.
interface pea_cfg_ctrl_if #(
  parameter int CFG_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/pea_cfg_ctrl.sv
// PEA configuration and run controller.
// A loader fills a shadow bank (header + one word per PE). A separate run FSM
// commits the shadow bank into the active bank on start and counts output
// samples until the programmed iteration count is reached.
//
// Loader FSM
//   state   | meaning
//   LD_HDR  | waiting for header word (iter_cnt, acc_val)
//   LD_PE   | receiving per-PE control words, idx selects the PE
//   LD_FULL | shadow bank complete, waiting for commit
//
// Run FSM
//   state      | meaning
//   RUN_IDLE   | no kernel running, commit allowed
//   RUN_ACTIVE | PEA enabled, counting output samples
module pea_cfg_ctrl #(
  parameter int N_PE          = 16,
  parameter int N_CFG_BITS_PE = 12,
  parameter int CFG_W         = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  pea_cfg_ctrl_if.slave                   cfg,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            out_valid_i,
  output logic [N_PE*N_CFG_BITS_PE-1:0]   ctrl_pe_o,
  output logic [7:0]                      reg_acc_value_o,
  output logic                            pea_en_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            cfg_err_o
);

  localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PE - 1);

  typedef enum logic [1:0] {LD_HDR, LD_PE, LD_FULL} ld_state_t;
  typedef enum logic {RUN_IDLE, RUN_ACTIVE} run_state_t;

  ld_state_t  ld_state_q, ld_state_d;
  run_state_t run_state_q, run_state_d;

  logic [IDX_W-1:0]          idx_q;
  logic [N_CFG_BITS_PE-1:0]  shadow_q [N_PE];
  logic [15:0]               sh_iter_q;
  logic [7:0]                sh_acc_q;

  logic [N_PE*N_CFG_BITS_PE-1:0] act_q;
  logic [7:0]                    acc_q;
  logic [15:0]                   iter_q;
  logic [15:0]                   smp_cnt_q;
  logic                          done_q;
  logic                          err_q;

  logic cfg_ready;
  logic hs;
  logic commit;
  logic frame_err;
  logic hdr_we;
  logic pe_we;
  logic idx_inc;
  logic idx_clr;
  logic run_end;
  logic cnt_inc;
  logic do_abort;

  // Upper header bits carry no meaning for this controller.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg.cfg_data;

  assign cfg_ready     = (ld_state_q != LD_FULL);
  assign cfg.cfg_ready = cfg_ready;
  assign hs            = cfg.cfg_valid && cfg_ready;
  assign commit        = start_i && (ld_state_q == LD_FULL) && (run_state_q == RUN_IDLE);
  assign do_abort      = (run_state_q == RUN_ACTIVE) && abort_i;

  // State registers for both FSMs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_state_q  <= LD_HDR;
      run_state_q <= RUN_IDLE;
    end else begin
      ld_state_q  <= ld_state_d;
      run_state_q <= run_state_d;
    end
  end

  // Loader next state: header, PE words, framing check on the last flag.
  always_comb begin
    ld_state_d = ld_state_q;
    frame_err  = 1'b0;
    hdr_we     = 1'b0;
    pe_we      = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    case (ld_state_q)
      LD_HDR: begin
        if (hs) begin
          if (cfg.cfg_last) begin
            frame_err = 1'b1;
          end else begin
            hdr_we     = 1'b1;
            idx_clr    = 1'b1;
            ld_state_d = LD_PE;
          end
        end
      end
      LD_PE: begin
        if (hs) begin
          pe_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            if (cfg.cfg_last) begin
              ld_state_d = LD_FULL;
            end else begin
              frame_err  = 1'b1;
              ld_state_d = LD_HDR;
            end
          end else if (cfg.cfg_last) begin
            frame_err  = 1'b1;
            ld_state_d = LD_HDR;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      LD_FULL: begin
        if (commit) ld_state_d = LD_HDR;
      end
      default: ld_state_d = LD_HDR;
    endcase
  end

  // Run next state: abort wins over end-of-run; iter_cnt of zero ends at once.
  always_comb begin
    run_state_d = run_state_q;
    run_end     = 1'b0;
    cnt_inc     = 1'b0;
    case (run_state_q)
      RUN_IDLE: begin
        if (commit) run_state_d = RUN_ACTIVE;
      end
      RUN_ACTIVE: begin
        if (abort_i) begin
          run_state_d = RUN_IDLE;
        end else if ((iter_q == 16'd0) ||
                     (out_valid_i && (smp_cnt_q == iter_q - 16'd1))) begin
          run_end     = 1'b1;
          run_state_d = RUN_IDLE;
        end else if (out_valid_i) begin
          cnt_inc = 1'b1;
        end
      end
      default: run_state_d = RUN_IDLE;
    endcase
  end

  // Shadow bank, PE index and sticky framing error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      sh_iter_q <= '0;
      sh_acc_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < N_PE; i++) shadow_q[i] <= '0;
    end else begin
      if (idx_clr) idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + IDX_W'(1);
      if (hdr_we) begin
        sh_iter_q <= cfg.cfg_data[15:0];
        sh_acc_q  <= cfg.cfg_data[23:16];
      end
      if (pe_we) shadow_q[idx_q] <= cfg.cfg_data[N_CFG_BITS_PE-1:0];
      if (frame_err) err_q <= 1'b1;
    end
  end

  // Active bank, sample counter and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q     <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      smp_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= run_end;
      if (commit) begin
        for (int i = 0; i < N_PE; i++)
          act_q[i*N_CFG_BITS_PE +: N_CFG_BITS_PE] <= shadow_q[i];
        acc_q     <= sh_acc_q;
        iter_q    <= sh_iter_q;
        smp_cnt_q <= '0;
      end else begin
        if (do_abort) act_q <= '0;
        if (cnt_inc) smp_cnt_q <= smp_cnt_q + 16'd1;
      end
    end
  end

  assign ctrl_pe_o       = act_q;
  assign reg_acc_value_o = acc_q;
  assign pea_en_o        = (run_state_q == RUN_ACTIVE);
  assign busy_o          = (run_state_q == RUN_ACTIVE);
  assign done_o          = done_q;
  assign cfg_err_o       = err_q;

endmodule

// File: doc/pea_cfg_ctrl.md
# pea_cfg_ctrl

Configuration and run controller for the Processing Element Array. It receives one kernel configuration as a header word plus one control word per PE, holds it in a shadow bank, and commits it atomically to the PEs' `ctrl_pe` inputs. It then counts output samples until the programmed iteration count is reached. Shadow and active banks are separate, so the next kernel can be loaded while the current one runs.

## Interface
Parameters:
- `N_PE`, 16: number of PEs driven.
- `N_CFG_BITS_PE`, 12: control-word width per PE.
- `CFG_W`, 32: configuration bus width; must be ≥ max(24, `N_CFG_BITS_PE`).

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `cfg_valid_i`  in  1  configuration word valid.
- `cfg_ready_o`  out  1  controller accepts a configuration word.
- `cfg_data_i`  in  `CFG_W`  configuration word.
- `cfg_last_i`  in  1  marks the final word of a configuration.
- `start_i`  in  1  request to commit the shadow bank and run.
- `abort_i`  in  1  stop the current run.
- `out_valid_i`  in  1  PEA output-sample valid, counted during a run.
- `ctrl_pe_o`  out  `N_PE`×`N_CFG_BITS_PE`  active control word per PE.
- `reg_acc_value_o`  out  8  active accumulation length, broadcast to all PEs.
- `pea_en_o`  out  1  PEA enabled (run in progress).
- `busy_o`  out  1  run FSM not idle.
- `done_o`  out  1  one-cycle pulse at end of run.
- `cfg_err_o`  out  1  sticky configuration framing error.

## Operation
- Handshake: a word transfers on a cycle where `cfg_valid_i` and `cfg_ready_o` are both 1.
- `cfg_ready_o` is 1 in loader states HDR and PE, and 0 in FULL.
- Loader FSM, states HDR → PE → FULL:
  - HDR: accepts the header. Bits [15:0] are `iter_cnt`; bits [23:16] are `acc_val`. Both go to shadow. Clears the PE index.
  - PE: each accepted word stores bits [`N_CFG_BITS_PE`-1:0] into `shadow[idx]`, then `idx` increments.
  - The word with `idx == N_PE-1` must carry `cfg_last_i=1`; the loader then goes to FULL.
  - Framing error: `cfg_last_i=1` on any other word (header included), or `cfg_last_i=0` on the final PE word. Either sets `cfg_err_o`, returns the loader to HDR and leaves the shadow bank partial.
  - FULL: holds until commit.
- Run FSM, states IDLE → RUN:
  - Commit happens when `start_i=1`, loader is FULL and run FSM is IDLE.
  - On commit, the shadow control words, `acc_val` and `iter_cnt` copy into the active registers; the sample counter clears; the loader returns to HDR; the run FSM enters RUN.
  - `start_i` under any other condition is ignored, not latched.
  - RUN: each `out_valid_i=1` increments the 16-bit sample counter. When the counter equals `iter_cnt`-1 and `out_valid_i=1`, the run ends.
  - `iter_cnt == 0`: the run ends on the first RUN cycle regardless of `out_valid_i`.
  - End of run: `done_o` pulses, `pea_en_o` drops, and the FSM returns to IDLE. The active bank keeps its values.
- Abort: `abort_i=1` in RUN returns to IDLE next cycle with no `done_o`; the active control words are cleared to 0; the shadow bank and loader state are untouched. `abort_i` in IDLE is ignored.
- Priority: `abort_i` has priority over end-of-run in the same cycle, so no `done_o` is produced.
- The loader runs fully in parallel with RUN. A new configuration can reach FULL during a run and commits on the next `start_i` after the run returns to IDLE.
- `cfg_err_o` clears only on `rst_i`.
- Reset values: all outputs 0 except `cfg_ready_o`; active and shadow banks 0; loader in HDR; run FSM in IDLE. `cfg_ready_o` is 1 from the first cycle after reset.
- Reset asserted mid-load or mid-run forces the reset state on the next edge, with no `done_o`.

## Timing
- Registered outputs: `ctrl_pe_o`, `reg_acc_value_o`, `pea_en_o`, `busy_o`, `done_o`, `cfg_err_o`.
- `cfg_ready_o` is combinational from loader state only; it never depends on `cfg_valid_i`.
- Commit: `start_i` sampled at edge t. From t+1, `ctrl_pe_o` and `reg_acc_value_o` show the new values, `pea_en_o`=`busy_o`=1, and `cfg_ready_o`=1.
- End of run: last `out_valid_i` sampled at edge t. At t+1, `done_o`=1 for exactly one cycle, `pea_en_o`=0 and `busy_o`=0.
- Back-to-back commit: the earliest next `start_i` is sampled at t+1, giving at least one idle cycle between runs.
- Minimum configuration time: `N_PE`+1 cycles at full throughput.

## Test plan
- Full load then start: header `iter_cnt=4`, `acc_val=3`; 16 PE words with value 0x100+i; `start_i`. Expect `ctrl_pe_o[i]`=0x100+i and `reg_acc_value_o`=3 one cycle later. After four `out_valid_i` pulses, with gaps, `done_o` pulses exactly once.
- Overlapped load: load kernel B during kernel A's RUN. Expect `cfg_ready_o` low once B reaches FULL; A's `ctrl_pe_o` stays unchanged until A's `done_o`. `start_i` the cycle after `done_o` applies B.
- Framing errors: `cfg_last_i` on PE word 5 → `cfg_err_o`=1, loader back to HDR, a following `start_i` is ignored. Then a correct load plus `start_i` runs normally while `cfg_err_o` stays 1.
- `iter_cnt=0`: after commit, `done_o` pulses on the second cycle with no `out_valid_i`.
- Abort: `abort_i` after 2 of 10 samples → `pea_en_o`=0, `ctrl_pe_o`=0, no `done_o`. With `abort_i` and the final `out_valid_i` in the same cycle, there is still no `done_o`.
- Reset mid-load: assert `rst_i` at PE word 7. Next cycle all outputs are 0 and `cfg_ready_o`=1; a fresh header is accepted as a header.
